// File: rtl/concat_wdma_pkg.sv
// Shared types and constants for the Concat write DMA.
package concat_wdma_pkg;

  // Beat width is built from the output parallelism and per-lane data width.
  localparam int TOUT        = 8;
  localparam int MAX_DAT_DW  = 64;
  localparam int DAT_DW      = TOUT * MAX_DAT_DW;

  localparam int BURST_LEN   = 16;
  localparam int LOG2_BURST  = 4;
  localparam int LOG2_W      = 10;
  localparam int LOG2_CHG    = 6;
  localparam int STRIDE_W    = 26;
  localparam int FIFO_DEPTH  = 32;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // Byte distance between consecutive bursts of one output line.
  localparam int BURST_BYTES = BURST_LEN * (DAT_DW / 8);

  // wr_req_pd layout: {len, out_base_addr, offset}.
  localparam int REQ_OFF_LSB  = 0;
  localparam int REQ_BASE_LSB = 32;
  localparam int REQ_LEN_LSB  = 64;
  localparam int REQ_PD_W     = LOG2_BURST + 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [REQ_PD_W-1:0] pack_req(
    input logic [LOG2_BURST-1:0] len,
    input logic [31:0]           base,
    input logic [31:0]           offset
  );
    return {len, base, offset};
  endfunction

endpackage

// File: rtl/concat_wdma_fifo.sv
// Response buffer: first-word-fall-through FIFO with occupancy count.
module concat_wdma_fifo
  import concat_wdma_pkg::*;
#(
  parameter int DW    = DAT_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Head is read combinationally so the write channel sees data the cycle it lands.
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/concat_wdma.sv
// Concat write DMA: buffers cls+feature beats and writes one line per channel group in bursts.
module concat_wdma
  import concat_wdma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           out_base_addr,
  input  logic [STRIDE_W-1:0]   out_surface_stride,
  input  logic [LOG2_CHG-1:0]   CH_in_div_Tout,
  input  logic [LOG2_W-1:0]     w_in,
  input  logic                  rd_resp_vld,
  output logic                  rd_resp_rdy,
  input  logic [DAT_DW-1:0]     rd_resp_pd,
  output logic                  wr_req_vld,
  input  logic                  wr_req_rdy,
  output logic [REQ_PD_W-1:0]   wr_req_pd,
  output logic                  wr_dat_vld,
  input  logic                  wr_dat_rdy,
  output logic [DAT_DW-1:0]     wr_dat_pd,
  output logic                  wr_dat_last,
  output logic                  done
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [LOG2_W:0]         w_out_reg;
  logic [LOG2_W:0]         w_last;
  logic [LOG2_W:0]         last_burst_idx;
  logic [LOG2_W:0]         burst_reg;
  logic [LOG2_CHG-1:0]     groups_reg;
  logic [LOG2_CHG-1:0]     group_reg;
  logic [31:0]             base_reg;
  logic [STRIDE_W-1:0]     stride_reg;
  logic [31:0]             line_base_reg;
  logic [31:0]             burst_off_reg;
  logic [LOG2_BURST-1:0]   beat_reg;
  logic [LOG2_BURST-1:0]   cur_len;
  logic                    last_burst;
  logic                    last_group;
  logic                    last_beat;
  logic                    push;
  logic                    pop;
  logic                    req_fire;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFO_CNT_W-1:0]   fifo_count;

  concat_wdma_fifo #(
    .DW    (DAT_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_resp_pd),
    .pop       (pop),
    .head      (wr_dat_pd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // w_last = w_out-1 gives both the index of the final burst and the tail length.
  assign w_last         = w_out_reg - (LOG2_W+1)'(1);
  assign last_burst_idx = w_last >> LOG2_BURST;
  assign last_burst     = (burst_reg == last_burst_idx);
  assign last_group     = (group_reg == groups_reg - LOG2_CHG'(1));
  assign cur_len        = last_burst ? w_last[LOG2_BURST-1:0] : LOG2_BURST'(BURST_LEN - 1);
  assign last_beat      = (beat_reg == cur_len);

  // A command is only offered once the whole burst is already buffered, so data never stalls on input.
  assign wr_req_vld  = (state_reg == CMD) &&
                       (fifo_count >= ({{(FIFO_CNT_W-LOG2_BURST){1'b0}}, cur_len} + FIFO_CNT_W'(1)));
  assign wr_req_pd   = pack_req(cur_len, base_reg, line_base_reg + burst_off_reg);
  assign wr_dat_vld  = (state_reg == DATA) && !fifo_empty;
  assign wr_dat_last = (state_reg == DATA) && last_beat;
  assign done        = (state_reg == DONE);
  assign rd_resp_rdy = (state_reg != IDLE) && !fifo_full;

  assign push     = rd_resp_vld && rd_resp_rdy;
  assign pop      = wr_dat_vld && wr_dat_rdy;
  assign req_fire = wr_req_vld && wr_req_rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: command and data phases strictly alternate per burst.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CMD;
      CMD:     if (req_fire) state_next = DATA;
      DATA:    if (pop && last_beat) state_next = (last_burst && last_group) ? DONE : CMD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job parameters, burst/group position and running address offsets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_out_reg     <= '0;
      groups_reg    <= '0;
      base_reg      <= '0;
      stride_reg    <= '0;
      group_reg     <= '0;
      burst_reg     <= '0;
      line_base_reg <= '0;
      burst_off_reg <= '0;
      beat_reg      <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        w_out_reg     <= {1'b0, w_in} + (LOG2_W+1)'(1);
        groups_reg    <= CH_in_div_Tout;
        base_reg      <= out_base_addr;
        stride_reg    <= out_surface_stride;
        group_reg     <= '0;
        burst_reg     <= '0;
        line_base_reg <= '0;
        burst_off_reg <= '0;
        beat_reg      <= '0;
      end
      if (req_fire) begin
        beat_reg <= '0;
      end
      if (pop) begin
        if (!last_beat) begin
          beat_reg <= beat_reg + LOG2_BURST'(1);
        end else if (last_burst) begin
          // Next line restarts at burst 0, one surface stride further on.
          burst_reg     <= '0;
          burst_off_reg <= '0;
          group_reg     <= group_reg + LOG2_CHG'(1);
          line_base_reg <= line_base_reg + {{(32-STRIDE_W){1'b0}}, stride_reg};
        end else begin
          burst_reg     <= burst_reg + (LOG2_W+1)'(1);
          burst_off_reg <= burst_off_reg + 32'(BURST_BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_wdma.sv
// Self-checking bench for concat_wdma with a queue-based reference model.
module tb_concat_wdma;
  import concat_wdma_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [31:0]           out_base_addr;
  logic [STRIDE_W-1:0]   out_surface_stride;
  logic [LOG2_CHG-1:0]   CH_in_div_Tout;
  logic [LOG2_W-1:0]     w_in;
  logic                  rd_resp_vld;
  logic                  rd_resp_rdy;
  logic [DAT_DW-1:0]     rd_resp_pd;
  logic                  wr_req_vld;
  logic                  wr_req_rdy;
  logic [REQ_PD_W-1:0]   wr_req_pd;
  logic                  wr_dat_vld;
  logic                  wr_dat_rdy;
  logic [DAT_DW-1:0]     wr_dat_pd;
  logic                  wr_dat_last;
  logic                  done;

  always #5 clk = ~clk;

  concat_wdma dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .out_base_addr      (out_base_addr),
    .out_surface_stride (out_surface_stride),
    .CH_in_div_Tout     (CH_in_div_Tout),
    .w_in               (w_in),
    .rd_resp_vld        (rd_resp_vld),
    .rd_resp_rdy        (rd_resp_rdy),
    .rd_resp_pd         (rd_resp_pd),
    .wr_req_vld         (wr_req_vld),
    .wr_req_rdy         (wr_req_rdy),
    .wr_req_pd          (wr_req_pd),
    .wr_dat_vld         (wr_dat_vld),
    .wr_dat_rdy         (wr_dat_rdy),
    .wr_dat_pd          (wr_dat_pd),
    .wr_dat_last        (wr_dat_last),
    .done               (done)
  );

  int tests = 0;
  int fails = 0;

  logic [REQ_PD_W-1:0] exp_cmd[$];
  logic [DAT_DW-1:0]   exp_dat[$];
  logic [DAT_DW-1:0]   in_q[$];

  int  in_acc, out_acc, cmd_cnt, done_cnt, done_cyc, last_dat_cyc, remaining;
  int  cyc = 0;
  bit  mon_en = 0;
  bit  abort_feed = 0;
  bit  dat_block = 0;
  int  req_pct = 100;
  int  dat_pct = 100;
  logic                req_stall_prev = 1'b0;
  logic                dat_stall_prev = 1'b0;
  logic [REQ_PD_W-1:0] prev_req_pd;
  logic [DAT_DW-1:0]   prev_dat_pd;
  logic [REQ_PD_W-1:0] mon_e;
  int                  mon_need;

  function automatic void check(string tag, logic [DAT_DW-1:0] obs, logic [DAT_DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Sink ready generation, refreshed just after each rising edge.
  initial begin
    wr_req_rdy = 1'b0;
    wr_dat_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_req_rdy = ($urandom_range(99) < req_pct);
      wr_dat_rdy = !dat_block && ($urandom_range(99) < dat_pct);
    end
  end

  // Protocol monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      req_stall_prev = 1'b0;
      dat_stall_prev = 1'b0;
    end else begin
      if (req_stall_prev) begin
        check("req_hold_vld", wr_req_vld, 1);
        check("req_hold_pd", wr_req_pd, prev_req_pd);
      end
      if (dat_stall_prev) begin
        check("dat_hold_vld", wr_dat_vld, 1);
        check("dat_hold_pd", wr_dat_pd, prev_dat_pd);
      end
      if (wr_req_vld) begin
        check("req_while_burst_open", remaining, 0);
        if (exp_cmd.size() > 0) begin
          mon_need = int'(exp_cmd[0][REQ_LEN_LSB +: LOG2_BURST]) + 1;
          check("req_before_buffered", (in_acc - out_acc) >= mon_need, 1);
        end
      end
      if (wr_dat_vld) begin
        check("dat_outside_burst", remaining > 0, 1);
        check("dat_last", wr_dat_last, remaining == 1);
      end
      if (rd_resp_vld && rd_resp_rdy) in_acc++;
      if (wr_req_vld && wr_req_rdy) begin
        check("cmd_expected", exp_cmd.size() > 0, 1);
        if (exp_cmd.size() > 0) begin
          mon_e = exp_cmd.pop_front();
          check("cmd_pd", wr_req_pd, mon_e);
          remaining = int'(mon_e[REQ_LEN_LSB +: LOG2_BURST]) + 1;
        end
        cmd_cnt++;
      end
      if (wr_dat_vld && wr_dat_rdy) begin
        check("dat_expected", exp_dat.size() > 0, 1);
        if (exp_dat.size() > 0) check("dat_pd", wr_dat_pd, exp_dat.pop_front());
        out_acc++;
        if (remaining > 0) remaining--;
        last_dat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      req_stall_prev = wr_req_vld && !wr_req_rdy;
      prev_req_pd    = wr_req_pd;
      dat_stall_prev = wr_dat_vld && !wr_dat_rdy;
      prev_dat_pd    = wr_dat_pd;
    end
  end

  // Streams in_q into the read-response port, with an initial delay and random gaps.
  task automatic feed(input int pre, input int gap_pct);
    int guard;
    if (pre > 0) begin
      repeat (pre) @(posedge clk);
      #1;
    end
    for (int i = 0; i < in_q.size() && !abort_feed; i++) begin
      rd_resp_vld = 1'b1;
      rd_resp_pd  = in_q[i];
      guard = 0;
      @(negedge clk);
      while (!rd_resp_rdy && !abort_feed && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 5000) begin
        check("feed_timeout", guard < 5000, 1);
        break;
      end
      if (abort_feed) break;
      @(posedge clk);
      #1;
      rd_resp_vld = 1'b0;
      while ($urandom_range(99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
    end
    rd_resp_vld = 1'b0;
  endtask

  // One transfer: build the expected commands/beats, launch, and check completion.
  task automatic run_case(input int ch, input int win, input logic [31:0] base,
                          input logic [STRIDE_W-1:0] stride, input int pre, input int gap,
                          input int rq, input int dp, input bit full_test,
                          input bit extra_start, input int abort_at);
    int w_out, nb, len, total, ncmd, guard;
    longint off;
    logic [DAT_DW-1:0] beat;
    w_out = win + 1;
    nb    = (w_out + BURST_LEN - 1) / BURST_LEN;
    total = ch * w_out;
    exp_cmd.delete();
    exp_dat.delete();
    in_q.delete();
    for (int g = 0; g < ch; g++) begin
      for (int b = 0; b < nb; b++) begin
        len = (b == nb - 1) ? (w_out - BURST_LEN * (nb - 1) - 1) : BURST_LEN - 1;
        off = longint'(g) * longint'(stride) + longint'(b) * BURST_LEN * (DAT_DW / 8);
        exp_cmd.push_back({LOG2_BURST'(len), base, off[31:0]});
      end
    end
    ncmd = exp_cmd.size();
    for (int i = 0; i < total; i++) begin
      for (int k = 0; k < DAT_DW / 32; k++) beat[k*32 +: 32] = $urandom;
      in_q.push_back(beat);
      exp_dat.push_back(beat);
    end
    in_acc = 0; out_acc = 0; cmd_cnt = 0; done_cnt = 0;
    done_cyc = -10; last_dat_cyc = -100; remaining = 0;
    abort_feed = 0;
    req_pct = rq;
    dat_pct = dp;
    dat_block = full_test;
    mon_en = 1;
    CH_in_div_Tout     = LOG2_CHG'(ch);
    w_in               = LOG2_W'(win);
    out_base_addr      = base;
    out_surface_stride = stride;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      feed(pre, gap);
    join_none
    if (extra_start) begin
      // Relaunch attempt mid-transfer with different settings must be ignored.
      repeat (3) @(posedge clk);
      #1;
      w_in = LOG2_W'(5);
      CH_in_div_Tout = LOG2_CHG'(3);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (full_test) begin
      repeat (40) @(posedge clk);
      #1;
      check("fifo_full_accepts", in_acc, FIFO_DEPTH);
      check("fifo_full_rdy", rd_resp_rdy, 0);
      check("fifo_full_no_pop", out_acc, 0);
      dat_block = 0;
    end
    if (abort_at > 0) begin
      guard = 0;
      while (out_acc < abort_at && guard < 5000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("abort_wait_timeout", guard < 5000, 1);
      mon_en = 0;
      abort_feed = 1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_req_vld", wr_req_vld, 0);
      check("abort_dat_vld", wr_dat_vld, 0);
      check("abort_dat_last", wr_dat_last, 0);
      check("abort_done", done, 0);
      check("abort_idle_rdy", rd_resp_rdy, 0);
      wait fork;
      @(posedge clk);
      #1;
      $display("[TB] aborted ch=%0d w_in=%0d after %0d beats", ch, win, out_acc);
      return;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("done_timeout", guard < 20000, 1);
    check("done_latency", done_cyc, last_dat_cyc + 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_width", done_cnt, 1);
    check("cmd_count", cmd_cnt, ncmd);
    check("beat_count", out_acc, total);
    check("in_count", in_acc, total);
    check("cmd_left", exp_cmd.size(), 0);
    wait fork;
    mon_en = 0;
    $display("[TB] case ch=%0d w_in=%0d cmds=%0d beats=%0d", ch, win, cmd_cnt, out_acc);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_base_addr = '0;
    out_surface_stride = '0;
    CH_in_div_Tout = '0;
    w_in = '0;
    rd_resp_vld = 1'b0;
    rd_resp_pd = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_vld", wr_req_vld, 0);
    check("rst_dat_vld", wr_dat_vld, 0);
    check("rst_dat_last", wr_dat_last, 0);
    check("rst_done", done, 0);
    check("rst_resp_rdy", rd_resp_rdy, 0);
    @(posedge clk);
    #1;

    // Single-burst line.
    run_case(1, 3, 32'h1000_0000, 26'h800, 0, 0, 100, 100, 0, 0, 0);
    // Multi-burst with short tail.
    run_case(2, 20, 32'h2000_0000, 26'h4000, 0, 0, 100, 100, 0, 0, 0);
    // Exact multiple of the burst length.
    run_case(1, 15, 32'h3000_0000, 26'h100, 0, 0, 100, 100, 0, 0, 0);
    // Backpressure on both write channels, delayed input, ignored restart.
    run_case(3, 37, 32'h4000_0000, 26'h2_0000, 10, 30, 50, 50, 0, 1, 0);
    // Buffer fills while the data channel is blocked.
    run_case(1, 47, 32'h5000_0000, 26'h800, 0, 0, 100, 100, 1, 0, 0);
    // Reset during the fifth beat, then a fresh transfer.
    run_case(1, 20, 32'h6000_0000, 26'h800, 0, 0, 100, 100, 0, 0, 4);
    run_case(2, 20, 32'h6000_0000, 26'h800, 0, 0, 100, 100, 0, 0, 0);
    // Boundary sizes: widest line, most groups with large stride.
    run_case(1, 1023, 32'h7000_0000, 26'h1000, 0, 0, 100, 100, 0, 0, 0);
    run_case(63, 2, 32'hFFFF_FF00, 26'h3FF_FFFF, 0, 0, 100, 100, 0, 0, 0);
    // Randomized transfers.
    for (int r = 0; r < 4; r++) begin
      run_case($urandom_range(1, 4), $urandom_range(1, 70), $urandom, STRIDE_W'($urandom),
               $urandom_range(0, 5), $urandom_range(0, 40), $urandom_range(30, 100),
               $urandom_range(30, 100), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
